// File: rtl/tt_um_serial_add_seq.sv
// Bit-serial adder sequencer: A+B (or R+A) via one full-adder cell, result 10 cycles after start is first sampled.
// No backpressure: start edges seen while busy or done are dropped; clear only acts in IDLE.
module tt_um_serial_add_seq #(
  parameter int N_BITS = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int CNT_W = $clog2(N_BITS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [2:0]        sync_q1;
  logic [2:0]        sync_q2;
  logic              start_s;
  logic              acc_s;
  logic              clr_s;
  logic              start_d;
  logic              start_rise;

  logic [N_BITS-1:0] x_q;
  logic [N_BITS-1:0] y_q;
  logic [N_BITS-1:0] s_q;
  logic [N_BITS-1:0] r_q;
  logic              c_q;
  logic              cf_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [N_BITS-1:0] opa_ext;
  logic [N_BITS-1:0] opb_ext;
  logic [N_BITS-1:0] sum_word;
  logic              ha0_s;
  logic              ha0_c;
  logic              ha1_c;
  logic              sum_bit;
  logic              carry_nxt;
  logic              last_bit;
  logic              unused_ok;

  assign opa_ext = {{(N_BITS-4){1'b0}}, ui_in[3:0]};
  assign opb_ext = {{(N_BITS-4){1'b0}}, ui_in[7:4]};

  assign start_s    = sync_q2[0];
  assign acc_s      = sync_q2[1];
  assign clr_s      = sync_q2[2];
  assign start_rise = start_s & ~start_d;

  // One-bit adder cell built from two half adders; carry lives in c_q.
  assign ha0_s     = x_q[0] ^ y_q[0];
  assign ha0_c     = x_q[0] & y_q[0];
  assign sum_bit   = ha0_s ^ c_q;
  assign ha1_c     = ha0_s & c_q;
  assign carry_nxt = ha0_c | ha1_c;

  assign last_bit = (cnt_q == CNT_W'(N_BITS - 1));
  assign sum_word = {sum_bit, s_q[N_BITS-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      start_d <= 1'b0;
    end else begin
      sync_q1 <= uio_in[2:0];
      sync_q2 <= sync_q1;
      start_d <= start_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_rise) state <= ST_ADD;
        ST_ADD:  if (last_bit)   state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      s_q   <= '0;
      r_q   <= '0;
      c_q   <= 1'b0;
      cf_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            y_q   <= opa_ext;
            x_q   <= acc_s ? r_q : opb_ext;
            c_q   <= 1'b0;
            cnt_q <= '0;
          end else if (clr_s) begin
            r_q  <= '0;
            cf_q <= 1'b0;
          end
        end
        ST_ADD: begin
          c_q   <= carry_nxt;
          s_q   <= sum_word;
          x_q   <= {1'b0, x_q[N_BITS-1:1]};
          y_q   <= {1'b0, y_q[N_BITS-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            r_q  <= sum_word;
            cf_q <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = r_q[7:0];
  assign uio_out = {1'b0, cf_q, (state == ST_DONE), (state == ST_ADD), 4'b0000};
  assign uio_oe  = 8'hF0;

  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

endmodule
